mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Merges the cpu instruction-memory port (imemory_*) and data-memory port
//  (dmemory_*) onto a single valid/ready memory bus, directly downstream of cpu.
//  Grants one requester at a time and holds the grant until memory signals ready.
//  Alternates grants under contention so that neither fetch nor load/store starves.
//  Handoff between requesters is back-to-back: no dead cycle.
// PARAMETERS
//  DATA_FIRST  1   in IDLE with both valid: 1 = data port wins, 0 = instruction port wins
//  ADDR_WIDTH  32  address width of all three ports
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  imemory_valid/instr/addr/wdata/wstrb  in   1/1/AW/32/4  instruction requester
//  imemory_rdata/ready                   out  32/1         response to instruction requester
//  dmemory_valid/instr/addr/wdata/wstrb  in   1/1/AW/32/4  data requester
//  dmemory_rdata/ready                   out  32/1         response to data requester
//  memory_valid/instr/addr/wdata/wstrb   out  1/1/AW/32/4  request to shared memory
//  memory_rdata/ready                    in   32/1         response from shared memory
// BEHAVIOUR
//  Protocol, all ports
//   - Requester holds valid and all payload stable until ready.
//   - ready is a one-cycle pulse and completes the transfer.
//   - rdata is valid only in the cycle ready is high.
//  State machine: IDLE, GNT_I, GNT_D. State is held in flops; async reset forces IDLE.
//  IDLE
//   - Both valid: go to GNT_D if DATA_FIRST, else GNT_I.
//   - Only one valid: go to its grant state.
//   - Neither valid: stay in IDLE.
//   - memory_valid = 0 in IDLE. Request-to-bus latency is therefore 1 cycle.
//  GNT_x, memory_ready = 1 (completion cycle)
//   - Go to the other GNT state if the other port's valid = 1, else go to IDLE.
//   - The completing port's valid is ignored in this cycle (strict alternation under contention).
//  GNT_x, granted valid = 0 and memory_ready = 0 (requester abort, e.g. pipeline flush)
//   - Next state is IDLE. memory_valid drops in the same cycle.
//   - Memory must tolerate a withdrawn request.
//  GNT_x, otherwise: hold the grant.
//  Outputs (combinational from state and inputs)
//   - memory_valid = granted port's valid, and 0 in IDLE.
//   - memory_instr/addr/wdata/wstrb = granted port's payload, all zeros in IDLE.
//   - Granted port's ready = memory_ready. The ungranted port's ready = 0.
//   - memory_ready seen in IDLE is ignored and reaches neither port.
//   - imemory_rdata and dmemory_rdata = memory_rdata, unconditionally; consumers qualify with ready.
//  Reset values (during rst): state IDLE; all memory_* outputs 0; imemory_ready = dmemory_ready = 0.
//  Reset mid-transaction: the grant is dropped immediately (async) and no ready is forwarded.
//   After release, arbitration restarts from IDLE.
//  At most one transfer is outstanding. No buffering and no reordering.
//  Widths are passed through unchanged. No arithmetic is performed.
// TESTING
//  1. Fetch only: imemory_valid=1, addr=0x100, instr=1; memory_ready after 2 cycles with rdata=0xDEADBEEF
//     -> memory_addr=0x100 from cycle 1; imemory_ready pulses 1 cycle with rdata 0xDEADBEEF; dmemory_ready stays 0.
//  2. DATA_FIRST=1: imemory (0x104) and dmemory store (0x2000, wdata=0x12345678, wstrb=0xF) valid in the same cycle
//     -> store is served first; in the cycle after its ready, memory_addr=0x104 with no IDLE gap.
//  3. dmemory re-requests continuously while imemory stays pending
//     -> grants alternate D,I,D,I; each port gets exactly one ready per turn.
//  4. GNT_I with imemory_valid dropped before ready
//     -> IDLE next cycle; memory_valid=0; a later stray memory_ready in IDLE gives no port ready.
//  5. rst asserted asynchronously mid-GNT_D
//     -> memory_valid=0 and dmemory_ready=0 before the next clk edge; after release, a new fetch is served normally.
//  6. DATA_FIRST=0 with both ports valid -> the instruction port is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the cpu instruction and data memory ports onto one
// shared valid/ready memory bus. One grant at a time, held until ready;
// grants alternate under contention and hand off with no dead cycle.
//
// Handshake (all three ports): a requester raises valid and holds valid and
// payload stable until ready; ready is a single-cycle pulse that completes
// the transfer; rdata is meaningful only in the cycle ready is high.
module mem_arbiter #(
  parameter logic DATA_FIRST = 1'b1,
  parameter int   ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction requester
  input  logic                  imemory_valid,
  input  logic                  imemory_instr,
  input  logic [ADDR_WIDTH-1:0] imemory_addr,
  input  logic [31:0]           imemory_wdata,
  input  logic [3:0]            imemory_wstrb,
  output logic [31:0]           imemory_rdata,
  output logic                  imemory_ready,
  // data requester
  input  logic                  dmemory_valid,
  input  logic                  dmemory_instr,
  input  logic [ADDR_WIDTH-1:0] dmemory_addr,
  input  logic [31:0]           dmemory_wdata,
  input  logic [3:0]            dmemory_wstrb,
  output logic [31:0]           dmemory_rdata,
  output logic                  dmemory_ready,
  // shared memory
  output logic                  memory_valid,
  output logic                  memory_instr,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic [31:0]           memory_wdata,
  output logic [3:0]            memory_wstrb,
  input  logic [31:0]           memory_rdata,
  input  logic                  memory_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  // State register; async reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitrate from IDLE, alternate on completion, release on abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (imemory_valid && dmemory_valid) begin
          state_d = DATA_FIRST ? GNT_D : GNT_I;
        end else if (imemory_valid) begin
          state_d = GNT_I;
        end else if (dmemory_valid) begin
          state_d = GNT_D;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I: begin
        // On completion the finishing port's own valid is ignored so a
        // pending data request always gets the next turn.
        if (memory_ready) begin
          state_d = dmemory_valid ? GNT_D : IDLE;
        end else if (!imemory_valid) begin
          state_d = IDLE;
        end else begin
          state_d = GNT_I;
        end
      end
      GNT_D: begin
        if (memory_ready) begin
          state_d = imemory_valid ? GNT_I : IDLE;
        end else if (!dmemory_valid) begin
          state_d = IDLE;
        end else begin
          state_d = GNT_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux: route the granted port to memory and memory_ready back to it.
  always_comb begin
    memory_valid  = 1'b0;
    memory_instr  = 1'b0;
    memory_addr   = '0;
    memory_wdata  = '0;
    memory_wstrb  = '0;
    imemory_ready = 1'b0;
    dmemory_ready = 1'b0;
    case (state_q)
      GNT_I: begin
        memory_valid  = imemory_valid;
        memory_instr  = imemory_instr;
        memory_addr   = imemory_addr;
        memory_wdata  = imemory_wdata;
        memory_wstrb  = imemory_wstrb;
        imemory_ready = memory_ready;
      end
      GNT_D: begin
        memory_valid  = dmemory_valid;
        memory_instr  = dmemory_instr;
        memory_addr   = dmemory_addr;
        memory_wdata  = dmemory_wdata;
        memory_wstrb  = dmemory_wstrb;
        dmemory_ready = memory_ready;
      end
      default: begin
        memory_valid  = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; consumers qualify it with their ready.
  assign imemory_rdata = memory_rdata;
  assign dmemory_rdata = memory_rdata;

endmodule
